// File: rtl/unlock_seq_detector.sv
// Bus-access unlock sequence detector with mismatch lockout and relock code.
// Optional feature: define UNLOCK_TIMEOUT_EN to abandon partial sequences after TIMEOUT_CYC idle clocks.
module unlock_seq_detector #(
    parameter int                          ADDR_W      = 4,
    parameter int                          SEQ_LEN     = 6,
    parameter logic [ADDR_W*SEQ_LEN-1:0]   KEY         = 24'h539BA2,
    parameter logic [ADDR_W-1:0]           RELOCK_CODE = 4'h0,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16,
    parameter int                          TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sel,
    input  logic                           wr,
    input  logic [ADDR_W-1:0]              ba,
    output logic                           unlocked,
    output logic [1:0]                     state_o,
    output logic [$clog2(SEQ_LEN+1)-1:0]   idx_o,
    output logic                           fail_pulse,
    output logic                           rd_valid,
    output logic [7:0]                     rd_data
);

    localparam int IDX_W = $clog2(SEQ_LEN + 1);
    localparam int LK_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MATCH    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    // Out-of-range parameters leave a visible marker block in the elaborated hierarchy.
    if ((ADDR_W < 1) || (ADDR_W > 8) || (SEQ_LEN < 2) || (SEQ_LEN > 16) || (MAX_FAIL < 1) ||
        (MAX_FAIL > 15) || (LOCKOUT_CYC < 1) || (TIMEOUT_CYC < 1)) begin : g_invalid_config
    end

    function automatic logic [ADDR_W-1:0] key_elem(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] e;
        e = KEY[ADDR_W-1:0];
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                e = KEY[ADDR_W*i +: ADDR_W];
            end
        end
        return e;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : (v + 4'h1);
    endfunction

    state_t            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [3:0]        fail_r, fail_nxt_s, fail_inc_s;
    logic [LK_W-1:0]   lk_r, lk_nxt_s;
    logic              fail_pulse_s;
    logic              unlocked_r, fail_pulse_r, rd_valid_r;
    logic [7:0]        rd_data_r;
    logic              wr_acc_s, rd_acc_s;

    assign wr_acc_s = sel & wr;
    assign rd_acc_s = sel & ~wr;

`ifdef UNLOCK_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_r, tmo_nxt_s;

    // Idle timer: any write reloads it; it only counts down while a partial sequence is held.
    always_comb begin
        tmo_nxt_s = tmo_r;
        if (wr_acc_s) begin
            tmo_nxt_s = TMO_W'(TIMEOUT_CYC - 1);
        end else if ((state_r == ST_MATCH) && (tmo_r != TMO_W'(0))) begin
            tmo_nxt_s = tmo_r - TMO_W'(1);
        end else begin
            tmo_nxt_s = tmo_r;
        end
    end

    // Idle timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= TMO_W'(0);
        end else begin
            tmo_r <= tmo_nxt_s;
        end
    end
`endif

    // Next-state logic: sequence matching, mismatch counting, lockout and relock.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        fail_nxt_s   = fail_r;
        lk_nxt_s     = lk_r;
        fail_pulse_s = 1'b0;
        fail_inc_s   = sat_inc(fail_r);
        case (state_r)
            ST_IDLE, ST_MATCH: begin
                if (wr_acc_s) begin
                    if (ba == key_elem(idx_r)) begin
                        fail_nxt_s = 4'd0;
                        if (idx_r == IDX_W'(SEQ_LEN - 1)) begin
                            state_nxt_s = ST_UNLOCKED;
                            idx_nxt_s   = IDX_W'(0);
                        end else begin
                            state_nxt_s = ST_MATCH;
                            idx_nxt_s   = idx_r + IDX_W'(1);
                        end
                    end else begin
                        fail_pulse_s = 1'b1;
                        fail_nxt_s   = fail_inc_s;
                        if (fail_inc_s == 4'(MAX_FAIL)) begin
                            state_nxt_s = ST_LOCKOUT;
                            idx_nxt_s   = IDX_W'(0);
                            lk_nxt_s    = LK_W'(LOCKOUT_CYC - 1);
                        end else if (ba == key_elem(IDX_W'(0))) begin
                            // The mismatching element may itself start a fresh attempt.
                            state_nxt_s = ST_MATCH;
                            idx_nxt_s   = IDX_W'(1);
                        end else begin
                            state_nxt_s = ST_IDLE;
                            idx_nxt_s   = IDX_W'(0);
                        end
                    end
`ifdef UNLOCK_TIMEOUT_EN
                end else if ((state_r == ST_MATCH) && (tmo_r == TMO_W'(0))) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_W'(0);
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_UNLOCKED: begin
                if (wr_acc_s && (ba == RELOCK_CODE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_UNLOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lk_r == LK_W'(0)) begin
                    state_nxt_s = ST_IDLE;
                    fail_nxt_s  = 4'd0;
                end else begin
                    lk_nxt_s = lk_r - LK_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_W'(0);
                fail_nxt_s  = 4'd0;
            end
        endcase
    end

    // State and registered outputs; read status is captured from the pre-access values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_W'(0);
            fail_r       <= 4'd0;
            lk_r         <= LK_W'(0);
            unlocked_r   <= 1'b0;
            fail_pulse_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= 8'h00;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            fail_r       <= fail_nxt_s;
            lk_r         <= lk_nxt_s;
            unlocked_r   <= (state_nxt_s == ST_UNLOCKED);
            fail_pulse_r <= fail_pulse_s;
            rd_valid_r   <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= {unlocked_r, state_r, fail_r, 1'b0};
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign unlocked   = unlocked_r;
    assign state_o    = state_r;
    assign idx_o      = idx_r;
    assign fail_pulse = fail_pulse_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;

endmodule
